compensation_column_ctrl: RTL

COMPENSATION_COLUMN_CTRL -- requirements
Module: compensation_column_ctrl

---
 rtl/compensation_column_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/compensation_column_ctrl.sv
// Column controller for a chain of compensation PEs: loads N_ROWS weights deepest-first,
// streams activation vectors, then drains the pipeline and pulses done.
//
// state  | meaning
// IDLE   | waiting for start; inputs latched on start
// LOAD   | N_ROWS weight reads plus one cycle for the last read to return
// STREAM | accepting num_act activation vectors, stalls on gaps
// DRAIN  | N_ROWS cycles for the last activation to reach the column tail
// DONE   | one-cycle done pulse, then back to IDLE
module compensation_column_ctrl #(
    parameter int N_ROWS = 4,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_act,
    output logic              cmem_rd_en,
    output logic [ADDR_W-1:0] cmem_addr,
    input  logic [2:0]        cmem_rdata,
    output logic [2:0]        cw_out,
    output logic              cw_valid,
    input  logic              act_in_valid,
    output logic              act_in_ready,
    output logic              act_valid,
    output logic              psum_valid,
    output logic              busy,
    output logic              done
);

    localparam int TW = $clog2(N_ROWS + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        state;
    logic [TW-1:0]     tmr;
    logic [CNT_W-1:0]  rem;
    logic [ADDR_W-1:0] base_q;
    logic              cw_valid_q;
    logic [N_ROWS-1:0] psum_sr;

    // Down-counter tmr doubles as the weight index during LOAD (N_ROWS-1 .. 0 -> tmr N_ROWS .. 1)
    assign cmem_rd_en   = (state == S_LOAD) && (tmr != '0);
    assign cmem_addr    = cmem_rd_en ? (base_q + ADDR_W'(tmr - TW'(1))) : '0;
    assign cw_valid     = cw_valid_q;
    assign cw_out       = cw_valid_q ? cmem_rdata : 3'd0;
    assign act_in_ready = (state == S_STREAM) && (rem != '0);
    assign act_valid    = act_in_valid && act_in_ready;
    assign psum_valid   = psum_sr[N_ROWS-1];
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            tmr        <= '0;
            rem        <= '0;
            base_q     <= '0;
            cw_valid_q <= 1'b0;
            psum_sr    <= '0;
        end else begin
            cw_valid_q <= cmem_rd_en;
            psum_sr[0] <= act_valid;
            for (int i = 1; i < N_ROWS; i++) begin
                psum_sr[i] <= psum_sr[i-1];
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        rem    <= num_act;
                        tmr    <= TW'(N_ROWS);
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (tmr == '0) begin
                        tmr   <= TW'(N_ROWS - 1);
                        state <= (rem != '0) ? S_STREAM : S_DRAIN;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                S_STREAM: begin
                    if (act_valid) begin
                        rem <= rem - CNT_W'(1);
                        if (rem == CNT_W'(1)) begin
                            tmr   <= TW'(N_ROWS - 1);
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (tmr == '0) begin
                        state <= S_DONE;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
